// File: rtl/pcpu_ctrl_pkg.sv
// Shared definitions for the PCPU pipeline control slice.
//   mdu_state_e      : MDU busy-timer FSM encoding (ST_RUN, ST_MDU_BUSY)
//   REG_ZERO         : hardwired-zero register index, never a hazard source
//   MDU_LAT_DEFAULT  : default multiply/divide latency in cycles
//   MDU_CNT_W        : latency counter width (covers latencies 1..255)
//   reg_hit()        : true when an ID source register matches the EX load target
package pcpu_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MDU_LAT_DEFAULT = 32;
  localparam int         MDU_CNT_W       = 8;

  function automatic logic reg_hit(input logic       uses,
                                   input logic [4:0] id_reg,
                                   input logic [4:0] ex_reg);
    reg_hit = uses && (id_reg == ex_reg);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the PCPU datapath and pipe_hazard_ctrl.
//   Hazard sources (datapath -> controller):
//     mem_wait, branch_taken, ex_memread, ex_rt, id_rs, id_rt,
//     id_uses_rs, id_uses_rt, id_is_mdu, id_reads_hilo
//   Pipeline controls (controller -> datapath):
//     pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_write,
//     mdu_start, mdu_busy, stall_cnt[CNT_W-1:0]
//   modport master : datapath side
//   modport slave  : controller side
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             mem_wait;
  logic             branch_taken;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_mdu;
  logic             id_reads_hilo;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             id_ex_write;
  logic             mdu_start;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output mem_wait, branch_taken, ex_memread, ex_rt, id_rs, id_rt,
           id_uses_rs, id_uses_rt, id_is_mdu, id_reads_hilo,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_write,
           mdu_start, mdu_busy, stall_cnt
  );

  modport slave (
    input  mem_wait, branch_taken, ex_memread, ex_rt, id_rs, id_rt,
           id_uses_rs, id_uses_rt, id_is_mdu, id_reads_hilo,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_write,
           mdu_start, mdu_busy, stall_cnt
  );

endinterface

// File: rtl/mdu_busy_timer.sv
// Multiply/divide busy tracker.
// A start pulse loads the latency counter with MDU_LAT; the counter then
// counts down every cycle (freezes do not pause it) and the FSM stays in
// ST_MDU_BUSY while it is non-zero.
//   clk    : clock
//   rst_n  : synchronous active-low reset, abandons any count in flight
//   start  : one-cycle MDU start pulse
//   busy   : MDU result not yet available in HI/LO
module mdu_busy_timer
  import pcpu_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam logic [MDU_CNT_W-1:0] LAT = MDU_CNT_W'(MDU_LAT);

  logic [MDU_CNT_W-1:0] cnt_d, cnt_q;
  mdu_state_e           state_d, state_q;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = LAT;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - MDU_CNT_W'(1);
    end
    // State mirrors the next counter value so busy is a clean flop output.
    state_d = (cnt_d != '0) ? ST_MDU_BUSY : ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign busy = (state_q == ST_MDU_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage PCPU.
// Resolves, highest priority first: data-memory freeze, taken-branch flush,
// load-use / MDU-busy stall, normal issue. Counts hazard stall cycles in a
// saturating counter.
//   clk    : pipeline clock
//   rst_n  : synchronous active-low reset
//   hz     : pipe_hazard_ctrl_if slave modport (hazard sources in,
//            pipeline enables/flushes, MDU start/busy and stall_cnt out)
module pipe_hazard_ctrl
  import pcpu_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  hz
);

  logic             mdu_busy;
  logic             ld_haz;
  logic             mdu_haz;
  logic             haz_stall;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             id_ex_write;
  logic             mdu_start;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  mdu_busy_timer #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdu_start),
    .busy  (mdu_busy)
  );

  // A load into $zero produces nothing to forward, so it never stalls.
  assign ld_haz  = hz.ex_memread && (hz.ex_rt != REG_ZERO) &&
                   (reg_hit(hz.id_uses_rs, hz.id_rs, hz.ex_rt) ||
                    reg_hit(hz.id_uses_rt, hz.id_rt, hz.ex_rt));
  assign mdu_haz = mdu_busy && (hz.id_is_mdu || hz.id_reads_hilo);

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mdu_start   = 1'b0;
    haz_stall   = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hz.mem_wait) begin
      // Full freeze; a taken branch is simply held in EX and seen again later.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
    end else if (hz.branch_taken) begin
      // The ID instruction is squashed, so any hazard it had is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ld_haz || mdu_haz) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      haz_stall   = 1'b1;
    end else begin
      mdu_start   = hz.id_is_mdu;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (haz_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.if_id_write = if_id_write;
  assign hz.if_id_flush = if_id_flush;
  assign hz.id_ex_flush = id_ex_flush;
  assign hz.id_ex_write = id_ex_write;
  assign hz.mdu_start   = mdu_start;
  assign hz.mdu_busy    = mdu_busy;
  assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl.
// dut   : MDU_LAT=4,  CNT_W=4 (main checks, counter saturation)
// dut_l : MDU_LAT=24, CNT_W=4 (reset abandoning a long MDU count)
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       mem_wait, branch_taken, ex_memread;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       id_uses_rs, id_uses_rt, id_is_mdu, id_reads_hilo;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl_if #(.CNT_W(4)) ifa ();
  pipe_hazard_ctrl_if #(.CNT_W(4)) ifl ();

  assign ifa.mem_wait      = mem_wait;
  assign ifa.branch_taken  = branch_taken;
  assign ifa.ex_memread    = ex_memread;
  assign ifa.ex_rt         = ex_rt;
  assign ifa.id_rs         = id_rs;
  assign ifa.id_rt         = id_rt;
  assign ifa.id_uses_rs    = id_uses_rs;
  assign ifa.id_uses_rt    = id_uses_rt;
  assign ifa.id_is_mdu     = id_is_mdu;
  assign ifa.id_reads_hilo = id_reads_hilo;

  assign ifl.mem_wait      = mem_wait;
  assign ifl.branch_taken  = branch_taken;
  assign ifl.ex_memread    = ex_memread;
  assign ifl.ex_rt         = ex_rt;
  assign ifl.id_rs         = id_rs;
  assign ifl.id_rt         = id_rt;
  assign ifl.id_uses_rs    = id_uses_rs;
  assign ifl.id_uses_rt    = id_uses_rt;
  assign ifl.id_is_mdu     = id_is_mdu;
  assign ifl.id_reads_hilo = id_reads_hilo;

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (ifa)
  );

  pipe_hazard_ctrl #(.MDU_LAT(24), .CNT_W(4)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (ifl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {rst_n, mem_wait, branch_taken, ex_memread}
  // uf  = {id_uses_rs, id_uses_rt, id_is_mdu, id_reads_hilo}
  // eo  = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, mdu_start, mdu_busy}
  typedef struct packed {
    logic [3:0] ctl;
    logic [4:0] ert;
    logic [4:0] irs;
    logic [4:0] irt;
    logic [3:0] uf;
    logic [6:0] eo;
    logic [3:0] ecnt;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [3:0] c, input logic [4:0] a,
                              input logic [4:0] b, input logic [4:0] d,
                              input logic [3:0] u, input logic [6:0] e,
                              input logic [3:0] n);
    vec_t v;
    v.ctl  = c;
    v.ert  = a;
    v.irs  = b;
    v.irt  = d;
    v.uf   = u;
    v.eo   = e;
    v.ecnt = n;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {rst_n, mem_wait, branch_taken, ex_memread} = v.ctl;
    ex_rt = v.ert;
    id_rs = v.irs;
    id_rt = v.irt;
    {id_uses_rs, id_uses_rt, id_is_mdu, id_reads_hilo} = v.uf;
  endtask

  task automatic cmp_vec(input vec_t v, input int i);
    chk("pc_write",    i, 32'(ifa.pc_write),    32'(v.eo[6]));
    chk("if_id_write", i, 32'(ifa.if_id_write), 32'(v.eo[5]));
    chk("id_ex_write", i, 32'(ifa.id_ex_write), 32'(v.eo[4]));
    chk("if_id_flush", i, 32'(ifa.if_id_flush), 32'(v.eo[3]));
    chk("id_ex_flush", i, 32'(ifa.id_ex_flush), 32'(v.eo[2]));
    chk("mdu_start",   i, 32'(ifa.mdu_start),   32'(v.eo[1]));
    chk("mdu_busy",    i, 32'(ifa.mdu_busy),    32'(v.eo[0]));
    chk("stall_cnt",   i, 32'(ifa.stall_cnt),   32'(v.ecnt));
  endtask

  vec_t idle_v;
  vec_t ld_v;
  vec_t mdu_v;
  vec_t rst_v;

  initial begin
    idle_v = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b0, 4'd0);
    ld_v   = mk(4'b1001, 5'd8, 5'd8, 5'd0, 4'b1000, 7'b0, 4'd0);
    mdu_v  = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b0, 4'd0);
    rst_v  = mk(4'b0000, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b0, 4'd0);

    vecs[0]  = mk(4'b0000, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b0011100, 4'd0);  // reset
    vecs[1]  = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b1110000, 4'd0);  // idle
    vecs[2]  = mk(4'b1001, 5'd8, 5'd8, 5'd0, 4'b1000, 7'b0010100, 4'd0);  // load-use rs
    vecs[3]  = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b1110000, 4'd1);  // released
    vecs[4]  = mk(4'b1001, 5'd0, 5'd0, 5'd0, 4'b1000, 7'b1110000, 4'd1);  // $zero load
    vecs[5]  = mk(4'b1001, 5'd5, 5'd0, 5'd5, 4'b0100, 7'b0010100, 4'd1);  // load-use rt
    vecs[6]  = mk(4'b1001, 5'd5, 5'd5, 5'd5, 4'b0000, 7'b1110000, 4'd2);  // match, unused
    vecs[7]  = mk(4'b1011, 5'd9, 5'd9, 5'd0, 4'b1000, 7'b1111100, 4'd2);  // branch beats ld
    vecs[8]  = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b1110010, 4'd2);  // mult starts
    vecs[9]  = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0001, 7'b0010101, 4'd2);  // mfhi stall 1
    vecs[10] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0001, 7'b0010101, 4'd3);
    vecs[11] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0001, 7'b0010101, 4'd4);
    vecs[12] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0001, 7'b0010101, 4'd5);  // stall 4
    vecs[13] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0001, 7'b1110000, 4'd6);  // mfhi issues
    vecs[14] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b1110010, 4'd6);  // mult starts
    vecs[15] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b1110001, 4'd6);  // counter 4
    vecs[16] = mk(4'b1110, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b0000001, 4'd6);  // freeze, cnt 3
    vecs[17] = mk(4'b1110, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b0000001, 4'd6);  // freeze, cnt 2
    vecs[18] = mk(4'b1110, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b0000001, 4'd6);  // freeze, cnt 1
    vecs[19] = mk(4'b1010, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b1111100, 4'd6);  // branch flushes
    vecs[20] = mk(4'b1101, 5'd8, 5'd8, 5'd0, 4'b1000, 7'b0000000, 4'd6);  // freeze beats ld
    vecs[21] = mk(4'b1100, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b0000000, 4'd6);  // no start in freeze
    vecs[22] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b1110000, 4'd6);
    vecs[23] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b1110010, 4'd6);  // mult A
    vecs[24] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b0010101, 4'd6);  // mult B waits
    vecs[25] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b0010101, 4'd7);
    vecs[26] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b0010101, 4'd8);
    vecs[27] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b0010101, 4'd9);
    vecs[28] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b1110010, 4'd10); // mult B starts
    vecs[29] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b1110001, 4'd10);
    vecs[30] = mk(4'b0001, 5'd8, 5'd8, 5'd0, 4'b1000, 7'b0011101, 4'd10); // reset mid-op
    vecs[31] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b1110000, 4'd0);  // cleared

    // Bring both instances out of an unknown power-up state.
    drive(rst_v);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #3;
      cmp_vec(vecs[i], i);
      @(posedge clk); #1;
    end

    // Saturation of the 4-bit stall counter: 15 stalls reach all-ones, more stay there.
    for (int i = 0; i < 15; i++) begin
      drive(ld_v);
      @(posedge clk); #1;
    end
    drive(idle_v);
    #3;
    chk("sat_reach", 0, 32'(ifa.stall_cnt), 32'd15);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      drive(ld_v);
      #3;
      chk("sat_stall_pc", i, 32'(ifa.pc_write), 32'd0);
      @(posedge clk); #1;
    end
    drive(idle_v);
    #3;
    chk("sat_hold", 0, 32'(ifa.stall_cnt), 32'd15);
    @(posedge clk); #1;

    // Long-latency instance: reset while its counter sits at 20.
    drive(mdu_v);
    #3;
    chk("long_start", 0, 32'(ifl.mdu_start), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive(idle_v);
      #3;
      chk("long_busy", i, 32'(ifl.mdu_busy), 32'd1);
      @(posedge clk); #1;
    end
    drive(rst_v);
    #3;
    chk("rst_busy_in_cycle", 0, 32'(ifl.mdu_busy),    32'd1);
    chk("rst_pc_write",      0, 32'(ifl.pc_write),    32'd0);
    chk("rst_if_id_write",   0, 32'(ifl.if_id_write), 32'd0);
    chk("rst_id_ex_write",   0, 32'(ifl.id_ex_write), 32'd1);
    chk("rst_if_id_flush",   0, 32'(ifl.if_id_flush), 32'd1);
    chk("rst_id_ex_flush",   0, 32'(ifl.id_ex_flush), 32'd1);
    chk("rst_mdu_start",     0, 32'(ifl.mdu_start),   32'd0);
    @(posedge clk); #1;
    drive(idle_v);
    #3;
    chk("post_rst_busy",     0, 32'(ifl.mdu_busy),    32'd0);
    chk("post_rst_cnt",      0, 32'(ifl.stall_cnt),   32'd0);
    chk("post_rst_pc_write", 0, 32'(ifl.pc_write),    32'd1);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage PCPU. Drives the PC write enable, the IF/ID write enable (IF_IDWrite) and the IF/ID and ID/EX flush strobes. It resolves load-use hazards, taken-branch flushes, data-memory wait freezes, and busy conditions of the multi-cycle multiply/divide unit (MDU). The MDU busy tracking uses an internal latency counter and FSM.

Parameters:
MDU_LAT, 32, MDU cycles from accepted start to result valid in HI/LO (valid range 1..255)
CNT_W, 16, width of the saturating hazard-stall performance counter

Ports:
clk  in  1  pipeline clock; all state updates on posedge
rst_n  in  1  reset, synchronous, active-low
mem_wait  in  1  data memory not ready; freeze the whole front end
branch_taken  in  1  branch/jump resolved taken in EX this cycle
ex_memread  in  1  instruction in EX is a load
ex_rt  in  5  load destination register in EX
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_is_mdu  in  1  ID instruction is mult/div (starts MDU)
id_reads_hilo  in  1  ID instruction is mfhi/mflo
pc_write  out  1  PC register load enable
if_id_write  out  1  IF/ID load enable (IF_IDWrite)
if_id_flush  out  1  replace IF/ID contents with NOP
id_ex_flush  out  1  insert bubble into ID/EX
id_ex_write  out  1  ID/EX load enable (0 only on freeze)
mdu_start  out  1  one-cycle start pulse to MDU
mdu_busy  out  1  MDU latency counter non-zero
stall_cnt  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset (rst_n=0 at posedge): mdu counter=0, FSM=RUN, stall_cnt=0. While rst_n=0 the outputs are pc_write=0, if_id_write=0, id_ex_write=1, if_id_flush=1, id_ex_flush=1, mdu_start=0. Reset mid-MDU-operation abandons the count; mdu_busy=0 the next cycle.
- Control outputs are combinational from inputs, FSM and counter. Counters are registered.
- Load-use hazard: ld_haz = ex_memread & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- MDU hazard: mdu_haz = mdu_busy & (id_is_mdu | id_reads_hilo).
- Priority per cycle, highest first:
  1. mem_wait: pc_write=0, if_id_write=0, id_ex_write=0, no flushes, mdu_start=0. A branch_taken during a freeze is ignored; it re-presents after the freeze.
  2. branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, mdu_start=0. A pending ld_haz or mdu_haz is discarded because the ID instruction is squashed.
  3. mdu_haz or ld_haz: pc_write=0, if_id_write=0, id_ex_flush=1, id_ex_write=1. stall_cnt increments, saturating at all-ones.
  4. Otherwise all enables are 1 and all flushes 0. mdu_start=id_is_mdu.
- FSM RUN/MDU_BUSY:
  - mdu_start in cycle t: counter<=MDU_LAT and FSM<=MDU_BUSY at t+1.
  - The counter decrements every cycle while non-zero, including during mem_wait.
  - Reaching 0 returns the FSM to RUN.
  - mdu_busy = (counter!=0) = (FSM==MDU_BUSY).
- Latency: a dependent mfhi/mflo in ID at t+1 stalls for cycles t+1..t+MDU_LAT and issues at t+MDU_LAT+1.
- Back-to-back mult/div stalls identically. A new start is legal only once the counter is 0.
- Register 0 never causes a load-use stall.
- The same cycle cannot produce both a flush and a stall.

Decomposition:
- Shared package pcpu_ctrl_pkg holds:
  - FSM state encoding (ST_RUN, ST_MDU_BUSY)
  - REG_ZERO=5'd0
  - MDU_LAT_DEFAULT
- One natural sub-module: mdu_busy_timer, containing the latency counter, FSM and busy output with a start input.
- Hazard priority logic stays in the top level.

Test Plan:
- ex_memread=1, ex_rt=8, id_rs=8, id_uses_rs=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 for exactly 1 cycle; stall_cnt 0->1.
- Same as above with ex_rt=0 -> no stall; all enables 1; stall_cnt stays 0.
- id_is_mdu=1 at cycle 10 with MDU_LAT=4, then id_reads_hilo=1 from cycle 11 -> mdu_start pulses at cycle 10; mdu_busy high for cycles 11-14; stall cycles 11-14; issue at cycle 15; stall_cnt=4.
- ld_haz and branch_taken together -> if_id_flush=1, id_ex_flush=1, pc_write=1; stall_cnt unchanged.
- mem_wait=1 for 3 cycles with branch_taken=1 and mdu_busy counting down from 3 -> all enables 0 with no flush for those 3 cycles; counter reaches 0; the flush occurs on the first cycle after mem_wait drops.
- rst_n=0 for one cycle while counter=20 -> counter=0 and mdu_busy=0 next cycle; stall_cnt=0; the reset-cycle outputs match the reset values.
